// File: rtl/vector_reverse_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vector_reverse_stream                                         |
// | Purpose  : Registered valid/ready bit/group reversal engine (4 modes).   |
// |            Define VREV_SKID_EN for the two-entry skid-buffered variant.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vector_reverse_stream #(
    parameter int WIDTH = 100,
    parameter int GROUP = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] dout_count
);

    localparam int NUM_GRP = WIDTH / GROUP;

    generate
        if (WIDTH < 2 || GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
            $error("vector_reverse_stream: WIDTH must be >= 2 and a multiple of GROUP");
        end
    endgenerate

    logic [WIDTH-1:0] w_rev_bits;
    logic [WIDTH-1:0] w_rev_grps;
    logic [WIDTH-1:0] w_rev_in_grp;
    logic [WIDTH-1:0] w_perm;
    logic             w_in_xfer;
    logic             w_out_xfer;

    logic             dout_valid_q, dout_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] count_q, count_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign w_rev_bits[gi] = din[WIDTH-1-gi];
    end

    for (genvar gk = 0; gk < NUM_GRP; gk++) begin : g_grp
        assign w_rev_grps[gk*GROUP +: GROUP] = din[(NUM_GRP-1-gk)*GROUP +: GROUP];
        for (genvar gj = 0; gj < GROUP; gj++) begin : g_in_grp
            assign w_rev_in_grp[gk*GROUP+gj] = din[gk*GROUP+GROUP-1-gj];
        end
    end

    always_comb begin
        w_perm = din;
        case (mode)
            2'd0:    w_perm = din;
            2'd1:    w_perm = w_rev_bits;
            2'd2:    w_perm = w_rev_grps;
            default: w_perm = w_rev_in_grp;
        endcase
    end

    assign w_in_xfer  = din_valid && din_ready;
    assign w_out_xfer = dout_valid_q && dout_ready;

`ifdef VREV_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q;

    // ready is registered as "skid empty next cycle", so it never sees dout_ready
    assign din_ready = rdy_q;

    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!dout_valid_q || dout_ready) begin
            if (skid_valid_q) begin
                dout_d       = skid_q;
                dout_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_in_xfer) begin
                dout_d       = w_perm;
                dout_valid_d = 1'b1;
            end else begin
                dout_valid_d = 1'b0;
            end
        end else if (w_in_xfer) begin
            skid_d       = w_perm;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            rdy_q        <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            rdy_q        <= !skid_valid_d;
        end
    end
`else
    assign din_ready = !dout_valid_q || dout_ready;

    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
        if (din_ready) begin
            dout_valid_d = w_in_xfer;
            if (w_in_xfer) begin
                dout_d = w_perm;
            end
        end
    end
`endif

    always_comb begin
        count_d = count_q;
        if (w_out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            count_q      <= '0;
        end else begin
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            count_q      <= count_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign dout_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_reverse_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vector_reverse_stream                                      |
// | Purpose  : Self-checking bench: 8-bit vector table, stall, reset, wrap,  |
// |            and 100-bit randomized traffic against a queue model.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vector_reverse_stream;

`ifdef VREV_SKID_EN
    localparam int   MAX_OCC     = 2;
    localparam logic EXP_RDY_RST = 1'b0;
`else
    localparam int   MAX_OCC     = 1;
    localparam logic EXP_RDY_RST = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
    logic [7:0] a_din, a_dout;
    logic [1:0] a_mode;
    logic [3:0] a_dout_count;

    logic        b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
    logic [99:0] b_din, b_dout;
    logic [1:0]  b_mode;
    logic [15:0] b_dout_count;

    vector_reverse_stream #(.WIDTH(8), .GROUP(4), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .din(a_din), .mode(a_mode),
        .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout(a_dout),
        .dout_count(a_dout_count)
    );

    vector_reverse_stream u_dut_b (
        .clk(clk), .reset(reset),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din(b_din), .mode(b_mode),
        .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout(b_dout),
        .dout_count(b_dout_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rx_b  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference permutations via streaming operators: mode 3 is a full reverse
    // followed by a group-order reverse.
    function automatic logic [7:0] ref8(input logic [7:0] d, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = d;
            2'd1:    r = {<<{d}};
            2'd2:    r = {<<4{d}};
            default: begin r = {<<{d}}; r = {<<4{r}}; end
        endcase
        return r;
    endfunction

    function automatic logic [99:0] ref100(input logic [99:0] d, input logic [1:0] m);
        logic [99:0] r;
        case (m)
            2'd0:    r = d;
            2'd1:    r = {<<{d}};
            2'd2:    r = {<<4{d}};
            default: begin r = {<<{d}}; r = {<<4{r}}; end
        endcase
        return r;
    endfunction

    // Scoreboard: sampled one time unit before each rising edge.
    logic [7:0]  qa[$];
    logic [99:0] qb[$];
    logic        a_hold_v = 1'b0, b_hold_v = 1'b0;
    logic [7:0]  a_hold;
    logic [99:0] b_hold;

    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            qa.delete();
            qb.delete();
            a_hold_v = 1'b0;
            b_hold_v = 1'b0;
        end else begin
            if (a_hold_v) begin
                chk("a_stall_valid", a_dout_valid, 1'b1);
                chk("a_stall_dout", a_dout, a_hold);
            end
            if (a_dout_valid && a_dout_ready) begin
                if (qa.size() == 0) chk("a_unexpected_word", 1'b1, 1'b0);
                else chk("a_order", a_dout, qa.pop_front());
            end
            a_hold_v = a_dout_valid && !a_dout_ready;
            a_hold   = a_dout;
            if (a_din_valid && a_din_ready) qa.push_back(ref8(a_din, a_mode));

            if (b_hold_v) begin
                chk("b_stall_valid", b_dout_valid, 1'b1);
                chk("b_stall_dout", b_dout, b_hold);
            end
            if (b_dout_valid && b_dout_ready) begin
                if (qb.size() == 0) chk("b_unexpected_word", 1'b1, 1'b0);
                else chk("b_order", b_dout, qb.pop_front());
                rx_b++;
            end
            b_hold_v = b_dout_valid && !b_dout_ready;
            b_hold   = b_dout;
            if (b_din_valid && b_din_ready) qb.push_back(ref100(b_din, b_mode));
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t        tbl[8];
    logic [7:0]  sw[4];
    logic [1:0]  sm[4];
    logic [7:0]  de[3];
    logic        took;
    logic [127:0] rnd;

    initial begin
        int idx, nacc, n, sent, guard;
        tbl[0] = '{8'hC1, 2'd0, 8'hC1};
        tbl[1] = '{8'hC1, 2'd1, 8'h83};
        tbl[2] = '{8'hC1, 2'd2, 8'h1C};
        tbl[3] = '{8'hC1, 2'd3, 8'h38};
        tbl[4] = '{8'hB2, 2'd1, 8'h4D};
        tbl[5] = '{8'hB2, 2'd2, 8'h2B};
        tbl[6] = '{8'hB2, 2'd3, 8'hD4};
        tbl[7] = '{8'h6E, 2'd3, 8'h67};
        sw = '{8'h12, 8'h34, 8'h56, 8'h78};
        sm = '{2'd1, 2'd2, 2'd2, 2'd2};
        de = '{8'h48, 8'h43, 8'h65};

        reset = 1'b0;
        a_din_valid = 1'b0; a_din = '0; a_mode = '0; a_dout_ready = 1'b1;
        b_din_valid = 1'b0; b_din = '0; b_mode = '0; b_dout_ready = 1'b1;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #2;
        chk("rst_a_valid", a_dout_valid, 1'b0);
        chk("rst_a_dout", a_dout, 8'h00);
        chk("rst_a_count", a_dout_count, 4'd0);
        chk("rst_a_ready", a_din_ready, EXP_RDY_RST);
        chk("rst_b_valid", b_dout_valid, 1'b0);
        chk("rst_b_count", b_dout_count, 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", a_din_ready, 1'b1);
        chk("post_rst_b_ready", b_din_ready, 1'b1);

        // Table vectors, back-to-back with dout_ready high
        a_din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din  = tbl[i].din;
            a_mode = tbl[i].mode;
            @(negedge clk);
            chk("vec_dout", a_dout, tbl[i].exp);
            chk("vec_valid", a_dout_valid, 1'b1);
            chk("vec_count", a_dout_count, 4'(i));
        end
        a_din_valid = 1'b0;
        @(negedge clk);
        chk("vec_idle_valid", a_dout_valid, 1'b0);
        chk("vec_final_count", a_dout_count, 4'd8);

        // Stall with continuous offer; mode switches to 2 after the first word
        a_dout_ready = 1'b0;
        a_din_valid  = 1'b1;
        idx = 0; nacc = 0;
        a_din = sw[0]; a_mode = sm[0];
        for (int c = 0; c < 6; c++) begin
            #4 took = a_din_valid && a_din_ready;
            @(negedge clk);
            if (took) begin
                nacc++; idx++;
                a_din = sw[idx]; a_mode = sm[idx];
            end
            chk("stall_hold_dout", a_dout, 8'h48);
            chk("stall_hold_valid", a_dout_valid, 1'b1);
        end
        chk("stall_accepted", nacc, MAX_OCC);
        chk("stall_din_ready", a_din_ready, 1'b0);

        // Release: drain in order, later words carry mode 2
        a_dout_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            #4 took = a_din_valid && a_din_ready;
            if (a_dout_valid && a_dout_ready) begin
                chk("drain_order", a_dout, de[n]);
                n++;
            end
            @(negedge clk);
            if (took) begin
                idx++;
                if (idx < 3) begin a_din = sw[idx]; a_mode = sm[idx]; end
                else a_din_valid = 1'b0;
            end
        end
        chk("drain_done", n, 3);
        chk("drain_count", a_dout_count, 4'd11);
        chk("drain_idle", a_dout_valid, 1'b0);

        // Fill the buffer, then reset between edges
        a_dout_ready = 1'b0;
        a_din_valid  = 1'b1;
        a_din = 8'h9A; a_mode = 2'd0;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            #4 took = a_din_valid && a_din_ready;
            @(negedge clk);
            if (took) begin
                idx++;
                if (idx < 2) a_din = 8'hBC;
                else a_din_valid = 1'b0;
            end
        end
        a_din_valid = 1'b0;
        chk("held_before_reset", a_dout, 8'h9A);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", a_dout_valid, 1'b0);
        chk("midrst_dout", a_dout, 8'h00);
        chk("midrst_count", a_dout_count, 4'd0);
        chk("midrst_ready", a_din_ready, EXP_RDY_RST);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        a_dout_ready = 1'b1;
        a_din_valid = 1'b1; a_din = 8'hF0; a_mode = 2'd1;
        @(negedge clk);
        a_din_valid = 1'b0;
        chk("fresh_dout", a_dout, 8'h0F);
        chk("fresh_valid", a_dout_valid, 1'b1);
        chk("fresh_count", a_dout_count, 4'd0);
        @(negedge clk);
        chk("fresh_alone", a_dout_valid, 1'b0);
        chk("fresh_count2", a_dout_count, 4'd1);

        // Counter wrap: 17 transfers on a 4-bit counter
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        a_din_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_din  = 8'($urandom);
            a_mode = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        chk("wrap_at_16", a_dout_count, 4'd0);
        a_din_valid = 1'b0;
        @(negedge clk);
        chk("wrap_17", a_dout_count, 4'd1);
        chk("wrap_idle", a_dout_valid, 1'b0);

        // 200 random 100-bit words with random handshakes
        sent = 0; guard = 0; took = 1'b0;
        b_din_valid = 1'b0;
        while (rx_b < 200 && guard < 4000) begin
            guard++;
            if (took) b_din_valid = 1'b0;
            if (!b_din_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                b_din  = rnd[99:0];
                b_mode = 2'($urandom_range(0, 3));
                b_din_valid = 1'b1;
            end
            b_dout_ready = ($urandom_range(0, 3) != 0);
            #4 took = b_din_valid && b_din_ready;
            if (took) sent++;
            @(negedge clk);
        end
        b_din_valid = 1'b0;
        chk("rand_received", rx_b, 200);
        chk("rand_count", b_dout_count, 16'd200);
        chk("rand_idle", b_dout_valid, 1'b0);
        chk("rand_a_queue_empty", qa.size(), 0);
        chk("rand_b_queue_empty", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vector_reverse_stream.md
# vector_reverse_stream

Streaming, parametrised bit/group reversal engine with a valid/ready handshake on both sides. It is the registered, multi-mode successor to the combinational 100-bit vector reverser. It sits between a producer and a consumer of WIDTH-bit words. Each accepted word is permuted according to a per-word mode and presented one cycle later. Back-pressure is absorbed without dropping or duplicating words.

## Interface
- WIDTH, 100: data word width in bits; must be ≥ 2.
- GROUP, 4: group size in bits for modes 2 and 3; WIDTH must be an integer multiple of GROUP (elaboration error otherwise).
- CNT_W, 16: width of the output word counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- din_valid  in  1  producer has a word.
- din_ready  out  1  block can accept a word.
- din  in  WIDTH  input word.
- mode  in  2  permutation for this word; sampled together with din.
- dout_valid  out  1  output word available.
- dout_ready  in  1  consumer accepts the word.
- dout  out  WIDTH  permuted word.
- dout_count  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

## Operation
- An input transfer occurs when din_valid && din_ready is high on a rising edge. An output transfer occurs when dout_valid && dout_ready is high on a rising edge.
- The permutation is computed combinationally from din/mode and registered on input transfer. The mode is captured per word, so changing mode never affects words already accepted.
  - Mode 0: pass-through, dout = din.
  - Mode 1: full bit reverse, dout[i] = din[WIDTH-1-i].
  - Mode 2: group-order reverse. Group k = din[k*GROUP +: GROUP]. Output group k = input group (WIDTH/GROUP-1-k); bit order inside groups is preserved.
  - Mode 3: bit reverse within each group. dout[k*GROUP+j] = din[k*GROUP+GROUP-1-j].
- Words leave in acceptance order. None are lost or duplicated.
- dout and dout_valid are held stable while dout_valid && !dout_ready.
- dout_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset values: dout_valid=0, dout=0, dout_count=0, all buffer storage empty. din_ready=1 when skid is disabled; with skid enabled, din_ready=1 from the first edge after reset deasserts and 0 while reset is asserted.
- Reset asserted mid-transfer discards all held words immediately (asynchronous). No output transfer is counted in that cycle.

## Timing
- Latency: a word accepted at edge N is visible on dout with dout_valid=1 after edge N. The consumer can take it at edge N+1 at the earliest.
- Throughput: one word per cycle when dout_ready is held high.
- Simultaneous input and output transfer in one cycle is legal. The occupancy is unchanged, the new word replaces or queues behind the departing one, and the counter increments.
- dout_valid never depends combinationally on dout_ready.

## Configuration
- VREV_SKID_EN defined:
  - Two-entry buffer: output register plus skid register.
  - din_ready is a registered signal equal to "skid register empty". It has no combinational path from dout_ready.
  - When the output stalls with a word held, one more word is accepted into skid. din_ready then drops the following cycle.
  - When the output register drains, skid moves to it on the same edge.
- VREV_SKID_EN undefined:
  - Single output register.
  - din_ready = !dout_valid || dout_ready, which is combinational.
  - Maximum occupancy is 1 word.
- Ordering, latency, modes and counter behave identically in both builds.

## Test plan
- WIDTH=8, GROUP=4, dout_ready=1; din=8'b1100_0001 sent with modes 0,1,2,3 on four consecutive cycles. Required dout sequence is 11000001, 10000011, 00011100, 00111000 on consecutive cycles; dout_count ends at 4.
- Default WIDTH=100, mode 1, 200 random words, random dout_ready. Every dout equals the bit-reversed din, in order, with no loss or duplication. dout_count=200.
- Stall: dout_ready=0, din_valid=1 continuously.
  - Skid build: exactly 2 words accepted, din_ready=0 from the following cycle, dout stable.
  - Non-skid build: exactly 1 word accepted.
  - Releasing dout_ready drains in order.
- Counter wrap with CNT_W=4: 17 output transfers, then dout_count=1.
- Reset asserted asynchronously between edges while 2 words are held. dout_valid=0, dout=0 and dout_count=0 immediately. After release, the next accepted word appears alone with no stale data.
- Mode change under stall: accept a word with mode 1, then change mode to 2 while it is stalled. The held dout is unchanged and the next word uses mode 2.
